uart_transmitter: RTL and testbench

Serial UART transmitter at the far end of the memory stage's UART TX port. The memory stage writes one byte per `tx_data_valid` strobe into a small FIFO. The block frames each byte as 8N1, or 8E1 when parity is configured, and shifts it out LSB-first on `uart_txd` at a fixed bit period. Status flags go back to the core so software can poll for completion and detect dropped bytes.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_fifo.sv | 53 +++++
 rtl/uart_transmitter.sv | 193 +++++++++++++++++++
 tb/tb_uart_transmitter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and the transmitter FSM encoding.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS            = 8;
    localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding the UART transmitter.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The caller guarantees push only when not full and pop only when not empty.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] push_data,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] head,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic [AW:0]               wr_ptr;
    logic [AW:0]               rd_ptr;

    // Storage array: written on accepted pushes, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: FIFO-buffered 8N1 UART transmitter, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_data_valid,
    output logic                      uart_txd,
    output logic                      tx_busy,
    output logic                      tx_full,
    output logic                      tx_overflow
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_t                 state;
    tx_state_t                 state_next;
    logic [CW-1:0]             baud_cnt;
    logic                      baud_done;
    logic [2:0]                bit_idx;
    logic [2:0]                bit_idx_next;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] shift_next;
    logic                      txd;
    logic                      txd_next;
    logic                      overflow;

    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

`ifdef UART_TX_PARITY_EN
    logic                      parity;
    logic                      parity_next;
`endif

    // A write while full is dropped even if a pop happens on the same edge.
    assign fifo_push = tx_data_valid & ~fifo_full;
    assign baud_done = (baud_cnt == BAUD_LAST);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; STOP chains straight into START when data is waiting.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!fifo_empty) state_next = ST_START;
            ST_START: if (baud_done) state_next = ST_DATA;
            ST_DATA: begin
                if (baud_done && (bit_idx == BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (baud_done) state_next = ST_STOP;
`endif
            ST_STOP: begin
                if (baud_done) begin
                    state_next = fifo_empty ? ST_IDLE : ST_START;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic: FIFO pop plus next values of the line and shift datapath.
    always_comb begin
        fifo_pop     = 1'b0;
        txd_next     = txd;
        shift_next   = shift;
        bit_idx_next = bit_idx;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity;
`endif
        case (state)
            ST_IDLE: fifo_pop = !fifo_empty;
            ST_START: begin
                if (baud_done) begin
                    txd_next     = shift[0];
                    bit_idx_next = '0;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        txd_next = parity;
`else
                        txd_next = 1'b1;
`endif
                    end else begin
                        shift_next   = shift >> 1;
                        txd_next     = shift[1];
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (baud_done) txd_next = 1'b1;
`endif
            ST_STOP: fifo_pop = baud_done && !fifo_empty;
            default: ;
        endcase
        if (fifo_pop) begin
            shift_next = fifo_head;
            txd_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_next = ^fifo_head;
`endif
        end
    end

    // Datapath registers; the line idles high and returns high on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txd     <= 1'b1;
            shift   <= '0;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            txd     <= txd_next;
            shift   <= shift_next;
            bit_idx <= bit_idx_next;
`ifdef UART_TX_PARITY_EN
            parity  <= parity_next;
`endif
        end
    end

    // Baud counter: held at zero in IDLE and wrapped on each bit/state expiry,
    // which is equivalent to clearing it on every state entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt <= '0;
        end else if ((state == ST_IDLE) || baud_done) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    // Sticky overflow flag for writes dropped on a full FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (tx_data_valid && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    assign uart_txd    = txd;
    assign tx_busy     = (state != ST_IDLE) || (fifo_count != '0);
    assign tx_full     = fifo_full;
    assign tx_overflow = overflow;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboard bench for uart_transmitter (CLKS_PER_BIT=4,
// FIFO_DEPTH=4). Parity checks are compiled in with UART_TX_PARITY_EN.
module tb_uart_transmitter;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned FRAME = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_data_valid = 1'b0;
    logic       uart_txd;
    logic       tx_busy;
    logic       tx_full;
    logic       tx_overflow;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [7:0]  sb[$];
    int unsigned start_q[$];

    uart_transmitter #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .uart_txd      (uart_txd),
        .tx_busy       (tx_busy),
        .tx_full       (tx_full),
        .tx_overflow   (tx_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input bit accept);
        @(negedge clk);
        tx_data       = b;
        tx_data_valid = 1'b1;
        if (accept) sb.push_back(b);
    endtask

    // Ends a write burst and scrambles tx_data to show it is only sampled on write.
    task automatic end_writes();
        @(negedge clk);
        tx_data_valid = 1'b0;
        tx_data       = 8'h3C;
    endtask

    task automatic wait_idle(input int unsigned budget, output int unsigned t);
        int unsigned n = 0;
        while (tx_busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
    endtask

    // Line receiver: samples every cycle of each bit and checks against the scoreboard.
    always begin : rx
        logic [3:0]  samp [FRAME_BITS];
        logic        aborted;
        logic        hold_ok;
        logic [7:0]  rx_byte;
        logic [31:0] exp;
        int unsigned t_start;
        @(negedge clk);
        if (rst === 1'b1 && uart_txd === 1'b0) begin
            aborted = 1'b0;
            t_start = cyc;
            for (int b = 0; b < FRAME_BITS; b++) begin
                for (int j = 0; j < CPB; j++) begin
                    if (b != 0 || j != 0) @(negedge clk);
                    if (rst !== 1'b1) aborted = 1'b1;
                    samp[b][j] = uart_txd;
                end
            end
            if (!aborted) begin
                hold_ok = 1'b1;
                for (int b = 0; b < FRAME_BITS; b++) begin
                    if (samp[b] != 4'b0000 && samp[b] != 4'b1111) hold_ok = 1'b0;
                end
                for (int i = 0; i < 8; i++) rx_byte[i] = samp[i + 1][0];
                exp = (sb.size() != 0) ? {24'd0, sb.pop_front()} : 32'hDEAD_BEEF;
                check("rx_bit_hold", hold_ok, 1'b1);
                check("rx_start", samp[0], 4'b0000);
                check("rx_data", {24'd0, rx_byte}, exp);
`ifdef UART_TX_PARITY_EN
                check("rx_parity", samp[8 + 1], {4{^exp[7:0]}});
`endif
                check("rx_stop", samp[FRAME_BITS - 1], 4'b1111);
                start_q.push_back(t_start);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int unsigned t0;
        int unsigned t1;
        int unsigned bad;

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {uart_txd, tx_busy, tx_full, tx_overflow}, 4'b1000);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_state", {uart_txd, tx_busy, tx_full, tx_overflow}, 4'b1000);
        end

        // Single byte: latency, bit order and frame length.
        start_q.delete();
        write_byte(8'hA5, 1'b1);
        end_writes();
        @(negedge clk);
        check("a5_start_latency", uart_txd, 1'b0);
        t0 = cyc;
        wait_idle(4 * FRAME, t1);
        check("a5_busy_fall", t1 - t0, FRAME);
        repeat (4) @(negedge clk);
        check("a5_frames", start_q.size(), 1);

        // Back-to-back frames.
        start_q.delete();
        write_byte(8'h00, 1'b1);
        write_byte(8'hFF, 1'b1);
        end_writes();
        wait_idle(6 * FRAME, t1);
        repeat (4) @(negedge clk);
        check("b2b_frames", start_q.size(), 2);
        if (start_q.size() == 2) check("b2b_gap", start_q[1] - start_q[0], FRAME);

        // Burst of six writes into a depth-4 FIFO.
        start_q.delete();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 2) check("burst_no_early_pop", uart_txd, 1'b1);
            if (i == 3) check("burst_pop_at_2nd", uart_txd, 1'b0);
            if (i == 5) check("burst_not_full_4", tx_full, 1'b0);
            if (i == 6) begin
                check("burst_full_5", tx_full, 1'b1);
                check("burst_no_ovf_yet", tx_overflow, 1'b0);
            end
            tx_data       = 8'(i);
            tx_data_valid = 1'b1;
            if (i < 6) sb.push_back(8'(i));
        end
        end_writes();
        check("burst_ovf", tx_overflow, 1'b1);
        check("burst_full_held", tx_full, 1'b1);
        wait_idle(8 * FRAME, t1);
        repeat (4) @(negedge clk);
        check("burst_frames", start_q.size(), 5);
        for (int i = 1; i < 5 && i < start_q.size(); i++) begin
            check("burst_gap", start_q[i] - start_q[i - 1], FRAME);
        end
        check("burst_drained", sb.size(), 0);
        check("burst_ovf_sticky", tx_overflow, 1'b1);

`ifdef UART_TX_PARITY_EN
        // Parity frames: 0x07 has odd weight, 0x03 even.
        write_byte(8'h07, 1'b1);
        end_writes();
        @(negedge clk);
        t0 = cyc;
        wait_idle(4 * FRAME, t1);
        check("par_len", t1 - t0, 32'd44);
        write_byte(8'h03, 1'b1);
        end_writes();
        wait_idle(4 * FRAME, t1);
        repeat (4) @(negedge clk);
`endif

        // Reset during data bit 3 of 0x5A with two bytes queued behind it.
        start_q.delete();
        write_byte(8'h5A, 1'b0);
        write_byte(8'h11, 1'b0);
        write_byte(8'h22, 1'b0);
        end_writes();
        check("rst_frame_started", uart_txd, 1'b0);
        repeat (16) @(negedge clk);
        check("rst_pre_bit3", {uart_txd, tx_busy}, 2'b11);
        #2 rst = 1'b0;
        #1 check("rst_async", {uart_txd, tx_busy, tx_full, tx_overflow}, 4'b1000);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({uart_txd, tx_busy} !== 2'b10) bad++;
        end
        check("post_rst_quiet", bad, 0);
        check("post_rst_frames", start_q.size(), 0);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
